// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch slice: state encoding, datapath widths, reset PC.
// The ERR state exists only when IF_MISALIGN_CHECK_EN is defined.
package inst_fetch_pkg;

   localparam int INSTRUCTION_WIDTH = 32;
   localparam int OPERAND_WIDTH     = 32;

   localparam logic [OPERAND_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      HOLD,
      DRAIN
`ifdef IF_MISALIGN_CHECK_EN
      , ERR
`endif
   } fetch_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction memory request/acknowledge channel between the fetch unit and instruction memory.
interface inst_fetch_if;
   import inst_fetch_pkg::*;

   logic                         req;
   logic [OPERAND_WIDTH-1:0]     addr;
   logic                         ack;
   logic [INSTRUCTION_WIDTH-1:0] rdata;

   modport master (output req, output addr, input ack, input rdata);
   modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/inst_fetch_pc_reg.sv
// Program counter register: redirect load has priority over the sequential +4 increment.
module pc_reg
   import inst_fetch_pkg::*;
#(
   parameter logic [OPERAND_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load,
   input  logic [OPERAND_WIDTH-1:0] target,
   input  logic                     incr,
   output logic [OPERAND_WIDTH-1:0] pc
);

   // The increment relies on natural 32-bit overflow to wrap past the top of memory.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= target;
      end else if (incr) begin
         pc <= pc + 32'd4;
      end
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch FSM with held instruction register feeding the immediate-extend stage.
// Optional feature: define IF_MISALIGN_CHECK_EN to trap misaligned redirects into a sticky ERR state.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [OPERAND_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic                         clk,
   input  logic                         rst,
   inst_fetch_if.master                 imem,
   input  logic                         redirect_valid,
   input  logic [OPERAND_WIDTH-1:0]     redirect_pc,
   input  logic                         stall,
   output logic [INSTRUCTION_WIDTH-1:0] inst,
   output logic [OPERAND_WIDTH-1:0]     inst_pc,
   output logic                         inst_valid
`ifdef IF_MISALIGN_CHECK_EN
   ,
   output logic                         misalign_err
`endif
);

   fetch_state_e             state;
   fetch_state_e             next_state;
   logic [OPERAND_WIDTH-1:0] pc;
   logic [OPERAND_WIDTH-1:0] drain_addr;
   logic [OPERAND_WIDTH-1:0] redirect_target;
   logic                     pc_load;
   logic                     pc_incr;

`ifdef IF_MISALIGN_CHECK_EN
   logic misalign;
   assign misalign        = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign redirect_target = redirect_pc;
   assign pc_load         = redirect_valid && !misalign && (state != ERR);
`else
   assign redirect_target = redirect_pc & ~32'h3;
   assign pc_load         = redirect_valid;
`endif

   assign pc_incr = (state == FETCH) && imem.ack && !redirect_valid;

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk    (clk),
      .rst    (rst),
      .load   (pc_load),
      .target (redirect_target),
      .incr   (pc_incr),
      .pc     (pc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A redirect with a request in flight must wait in DRAIN for the stale ack before refetching.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = FETCH;
         FETCH: begin
            if (redirect_valid) begin
               next_state = imem.ack ? FETCH : DRAIN;
            end else if (imem.ack) begin
               next_state = HOLD;
            end
         end
         HOLD: begin
            if (redirect_valid || !stall) begin
               next_state = FETCH;
            end
         end
         DRAIN: begin
            if (imem.ack) begin
               next_state = FETCH;
            end
         end
         default: next_state = state;
      endcase
`ifdef IF_MISALIGN_CHECK_EN
      if (misalign) begin
         next_state = ERR;
      end
`endif
   end

   always_comb begin
      imem.req  = (state == FETCH) || (state == DRAIN);
      imem.addr = (state == DRAIN) ? drain_addr : pc;
   end

   // drain_addr keeps the abandoned address on the bus after pc has moved to the redirect target.
   always_ff @(posedge clk) begin
      if (rst) begin
         inst       <= '0;
         inst_pc    <= '0;
         inst_valid <= 1'b0;
         drain_addr <= '0;
      end else begin
         if (redirect_valid) begin
            inst_valid <= 1'b0;
         end else if ((state == FETCH) && imem.ack) begin
            inst       <= imem.rdata;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
         end else if ((state == HOLD) && !stall) begin
            inst_valid <= 1'b0;
         end
         if ((state == FETCH) && redirect_valid && !imem.ack) begin
            drain_addr <= pc;
         end
      end
   end

`ifdef IF_MISALIGN_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_err <= 1'b0;
      end else if (misalign) begin
         misalign_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: expected instructions are queued at ack time and checked by a monitor.
module tb_inst_fetch;
   import inst_fetch_pkg::*;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic [31:0] w_inst;
   logic [31:0] w_inst_pc;
   logic        w_inst_valid;
`ifdef IF_MISALIGN_CHECK_EN
   logic        misalign_err;
   logic        w_misalign_err;
`endif

   int   n_checks = 0;
   int   n_fail   = 0;
   logic prev_valid = 1'b0;
   exp_t exp_q[$];

   inst_fetch_if imem ();
   inst_fetch_if imem_w ();

   inst_fetch u_dut (
      .clk            (clk),
      .rst            (rst),
      .imem           (imem.master),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall          (stall),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_valid     (inst_valid)
`ifdef IF_MISALIGN_CHECK_EN
      ,
      .misalign_err   (misalign_err)
`endif
   );

   inst_fetch #(
      .RESET_PC (32'hFFFF_FFFC)
   ) u_wrap (
      .clk            (clk),
      .rst            (rst),
      .imem           (imem_w.master),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0),
      .stall          (1'b0),
      .inst           (w_inst),
      .inst_pc        (w_inst_pc),
      .inst_valid     (w_inst_valid)
`ifdef IF_MISALIGN_CHECK_EN
      ,
      .misalign_err   (w_misalign_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
      end
   endtask

   task automatic wait_req();
      int i = 0;
      while (!imem.req && i < 20) begin
         tick();
         i++;
      end
      check_output("req_timeout", {31'd0, imem.req}, 32'd1);
   endtask

   // Waits for a request, checks its address, acks one cycle later and optionally queues the expectation.
   task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] data, input bit push);
      wait_req();
      check_output("imem_addr", imem.addr, addr);
      tick();
      check_output("imem_addr_stable", imem.addr, addr);
      imem.ack   = 1'b1;
      imem.rdata = data;
      if (push) exp_q.push_back('{inst: data, pc: addr});
      tick();
      imem.ack   = 1'b0;
      imem.rdata = '0;
   endtask

   // Every new instruction presented must match the head of the scoreboard queue.
   always @(negedge clk) begin
      if (inst_valid && !prev_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_inst: got %h at pc %h, required no instruction", inst, inst_pc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_output("sb_inst", inst, e.inst);
            check_output("sb_inst_pc", inst_pc, e.pc);
         end
      end
      prev_valid = inst_valid;
   end

   initial begin
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      stall          = 1'b0;
      imem.ack       = 1'b0;
      imem.rdata     = '0;
      imem_w.ack     = 1'b0;
      imem_w.rdata   = '0;
      tick();
      tick();
      check_output("rst_req", {31'd0, imem.req}, 32'd0);
      check_output("rst_valid", {31'd0, inst_valid}, 32'd0);
      check_output("rst_inst", inst, 32'd0);
      check_output("rst_inst_pc", inst_pc, 32'd0);
      rst = 1'b0;
      tick();

      check_output("wrap_req", {31'd0, imem_w.req}, 32'd1);
      check_output("wrap_addr0", imem_w.addr, 32'hFFFF_FFFC);
      imem_w.ack   = 1'b1;
      imem_w.rdata = 32'h0000_0011;
      tick();
      imem_w.ack   = 1'b0;
      check_output("wrap_inst", w_inst, 32'h0000_0011);
      check_output("wrap_inst_pc", w_inst_pc, 32'hFFFF_FFFC);
      check_output("wrap_valid", {31'd0, w_inst_valid}, 32'd1);
      tick();
      check_output("wrap_addr1", imem_w.addr, 32'h0000_0000);

      apply_stimulus(32'h0, 32'hF000_0067, 1'b1);
      tick();
      stall = 1'b1;
      apply_stimulus(32'h4, 32'h0000_0043, 1'b1);
      for (int i = 0; i < 3; i++) begin
         check_output("hold_inst", inst, 32'h0000_0043);
         check_output("hold_valid", {31'd0, inst_valid}, 32'd1);
         check_output("hold_req", {31'd0, imem.req}, 32'd0);
         if (i == 1) begin
            imem.ack   = 1'b1;
            imem.rdata = 32'h0000_0999;
         end
         tick();
         imem.ack   = 1'b0;
         imem.rdata = '0;
      end
      check_output("hold_ack_ignored", inst, 32'h0000_0043);
      stall = 1'b0;
      tick();

      wait_req();
      check_output("after_hold_addr", imem.addr, 32'h8);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      tick();
      redirect_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check_output("drain_req", {31'd0, imem.req}, 32'd1);
         check_output("drain_addr", imem.addr, 32'h8);
         check_output("drain_valid", {31'd0, inst_valid}, 32'd0);
         tick();
      end
      imem.ack   = 1'b1;
      imem.rdata = 32'h0000_0003;
      tick();
      imem.ack   = 1'b0;
      check_output("post_drain_addr", imem.addr, 32'h100);
      check_output("post_drain_valid", {31'd0, inst_valid}, 32'd0);
      apply_stimulus(32'h100, 32'h0000_0013, 1'b1);

      wait_req();
      check_output("seq_addr", imem.addr, 32'h104);
      imem.ack       = 1'b1;
      imem.rdata     = 32'hDEAD_BEEF;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      tick();
      imem.ack       = 1'b0;
      redirect_valid = 1'b0;
      check_output("coinc_req", {31'd0, imem.req}, 32'd1);
      check_output("coinc_addr", imem.addr, 32'h200);
      check_output("coinc_valid", {31'd0, inst_valid}, 32'd0);
      apply_stimulus(32'h200, 32'h0050_0093, 1'b1);

      wait_req();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      tick();
      redirect_pc    = 32'h400;
      tick();
      redirect_valid = 1'b0;
      check_output("latest_drain_addr", imem.addr, 32'h204);
      imem.ack   = 1'b1;
      imem.rdata = 32'h0000_0005;
      tick();
      imem.ack   = 1'b0;
      check_output("latest_wins_addr", imem.addr, 32'h400);
      stall = 1'b1;
      apply_stimulus(32'h400, 32'h0000_0073, 1'b1);

      redirect_valid = 1'b1;
      redirect_pc    = 32'h102;
      tick();
      redirect_valid = 1'b0;
      stall          = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
      for (int i = 0; i < 3; i++) begin
         check_output("misalign_err", {31'd0, misalign_err}, 32'd1);
         check_output("misalign_req", {31'd0, imem.req}, 32'd0);
         check_output("misalign_valid", {31'd0, inst_valid}, 32'd0);
         tick();
      end
`else
      check_output("misalign_addr", imem.addr, 32'h100);
      check_output("misalign_valid", {31'd0, inst_valid}, 32'd0);
      apply_stimulus(32'h100, 32'h0000_0017, 1'b1);
      wait_req();
      check_output("pre_rst_addr", imem.addr, 32'h104);
`endif

      rst = 1'b1;
      tick();
      check_output("midrst_req", {31'd0, imem.req}, 32'd0);
      check_output("midrst_valid", {31'd0, inst_valid}, 32'd0);
      check_output("midrst_inst", inst, 32'd0);
      rst = 1'b0;
      tick();
      wait_req();
      check_output("post_rst_addr", imem.addr, 32'h0);

      tick();
      check_output("sb_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
